tour_cmd_seq: RTL and testbench

TOUR_CMD_SEQ -- requirements
Module: tour_cmd_seq

---
 rtl/tour_cmd_seq_if.sv | 32 +++
 rtl/tour_cmd_seq.sv | 170 +++++++++++++++++
 tb/tb_tour_cmd_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tour_cmd_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : tour_cmd_seq_if
//  Description : Bundle of tour/UART/command-processor handshake signals for
//                tour_cmd_seq. The slave modport is the sequencer's view and
//                the master modport is the surrounding system's view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tour_cmd_seq_if;
    logic        start_tour;
    logic [7:0]  move;
    logic [4:0]  mv_indx;
    logic [15:0] cmd_UART;
    logic        cmd_rdy_UART;
    logic        clr_cmd_rdy_UART;
    logic        clr_cmd_rdy;
    logic        send_resp;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic [7:0]  resp;

    modport slave (
        input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );

    modport master (
        output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
        input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
    );
endinterface
`default_nettype wire

// File: rtl/tour_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tour_cmd_seq
//  Description : Knight's-tour command sequencer. Passes UART commands through
//                while idle; once a tour starts, turns each one-hot move into
//                a vertical leg (opcode 2) and a horizontal leg (opcode 3)
//                command, 24 moves per tour.
//  Options     : TOUR_ABORT_EN - when defined, a pending UART command seen in
//                a HOLD state aborts the tour back to IDLE.
//  Revision    : 1.0 - initial release
// ============================================================================
module tour_cmd_seq (
    input  wire logic     clk,
    input  wire logic     rst,
    tour_cmd_seq_if.slave tour_if
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] VERT   = 3'd1;
    localparam logic [2:0] HOLD_V = 3'd2;
    localparam logic [2:0] HORZ   = 3'd3;
    localparam logic [2:0] HOLD_H = 3'd4;

    localparam logic [4:0] LAST_MOVE  = 5'd23;
    localparam logic [3:0] OP_MOVE    = 4'h2;
    localparam logic [3:0] OP_FANFARE = 4'h3;
    localparam logic [7:0] HDG_N      = 8'h00;
    localparam logic [7:0] HDG_W      = 8'h3F;
    localparam logic [7:0] HDG_S      = 8'h7F;
    localparam logic [7:0] HDG_E      = 8'hBF;
    localparam logic [7:0] RESP_DONE  = 8'hA5;
    localparam logic [7:0] RESP_BUSY  = 8'h5A;

    logic [2:0]  state_q, state_d;
    logic [4:0]  mv_indx_q, mv_indx_d;
    logic [2:0]  move_sel;
    logic        move_none;
    logic [15:0] vert_cmd;
    logic [15:0] horz_cmd;
    logic        abort;

    assign move_none = (tour_if.move == 8'h00);

`ifdef TOUR_ABORT_EN
    assign abort = tour_if.cmd_rdy_UART;
`else
    assign abort = 1'b0;
`endif

    // Priority-encode the move: the lowest set bit wins for multi-hot input
    always_comb begin
        move_sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (tour_if.move[i]) begin
                move_sel = 3'(i);
            end
        end
    end

    // Translate the selected move into its vertical and horizontal leg commands
    always_comb begin
        vert_cmd = {OP_MOVE, HDG_N, 4'd2};
        horz_cmd = {OP_FANFARE, HDG_E, 4'd1};
        case (move_sel)
            3'd0: begin vert_cmd = {OP_MOVE, HDG_N, 4'd2}; horz_cmd = {OP_FANFARE, HDG_E, 4'd1}; end
            3'd1: begin vert_cmd = {OP_MOVE, HDG_N, 4'd2}; horz_cmd = {OP_FANFARE, HDG_W, 4'd1}; end
            3'd2: begin vert_cmd = {OP_MOVE, HDG_N, 4'd1}; horz_cmd = {OP_FANFARE, HDG_W, 4'd2}; end
            3'd3: begin vert_cmd = {OP_MOVE, HDG_S, 4'd1}; horz_cmd = {OP_FANFARE, HDG_W, 4'd2}; end
            3'd4: begin vert_cmd = {OP_MOVE, HDG_S, 4'd2}; horz_cmd = {OP_FANFARE, HDG_W, 4'd1}; end
            3'd5: begin vert_cmd = {OP_MOVE, HDG_S, 4'd2}; horz_cmd = {OP_FANFARE, HDG_E, 4'd1}; end
            3'd6: begin vert_cmd = {OP_MOVE, HDG_S, 4'd1}; horz_cmd = {OP_FANFARE, HDG_E, 4'd2}; end
            3'd7: begin vert_cmd = {OP_MOVE, HDG_N, 4'd1}; horz_cmd = {OP_FANFARE, HDG_E, 4'd2}; end
            default: ;
        endcase
    end

    // State and move-index registers; reset drops straight back to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mv_indx_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            mv_indx_q <= mv_indx_d;
        end
    end

    // Next-state logic: each move is VERT -> HOLD_V -> HORZ -> HOLD_H
    always_comb begin
        state_d   = state_q;
        mv_indx_d = mv_indx_q;
        case (state_q)
            IDLE: begin
                if (tour_if.start_tour) begin
                    state_d   = VERT;
                    mv_indx_d = 5'd0;
                end
            end
            VERT: begin
                // An empty move means the solver has nothing for us: give up
                if (move_none) begin
                    state_d = IDLE;
                end else if (tour_if.clr_cmd_rdy) begin
                    state_d = HOLD_V;
                end
            end
            HOLD_V: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tour_if.send_resp) begin
                    state_d = HORZ;
                end
            end
            HORZ: begin
                if (tour_if.clr_cmd_rdy) begin
                    state_d = HOLD_H;
                end
            end
            HOLD_H: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tour_if.send_resp) begin
                    if (mv_indx_q == LAST_MOVE) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = VERT;
                        mv_indx_d = mv_indx_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode: UART pass-through when idle, tour commands otherwise
    always_comb begin
        tour_if.cmd              = 16'h0000;
        tour_if.cmd_rdy          = 1'b0;
        tour_if.clr_cmd_rdy_UART = 1'b0;
        tour_if.resp             = RESP_BUSY;
        case (state_q)
            IDLE: begin
                tour_if.cmd              = tour_if.cmd_UART;
                tour_if.cmd_rdy          = tour_if.cmd_rdy_UART;
                tour_if.clr_cmd_rdy_UART = tour_if.clr_cmd_rdy;
                tour_if.resp             = RESP_DONE;
            end
            VERT: begin
                tour_if.cmd     = vert_cmd;
                tour_if.cmd_rdy = !move_none;
            end
            HOLD_V: begin
                tour_if.cmd = vert_cmd;
            end
            HORZ: begin
                tour_if.cmd     = horz_cmd;
                tour_if.cmd_rdy = 1'b1;
            end
            HOLD_H: begin
                tour_if.cmd  = horz_cmd;
                tour_if.resp = (mv_indx_q == LAST_MOVE) ? RESP_DONE : RESP_BUSY;
            end
            default: ;
        endcase
    end

    assign tour_if.mv_indx = mv_indx_q;

endmodule
`default_nettype wire

// File: tb/tb_tour_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tour_cmd_seq
//  Description : Self-checking bench for tour_cmd_seq. Stimulus pushes the
//                expected {cmd, resp, mv_indx} of every command it accepts;
//                a monitor pops and compares on each cmd_rdy/clr_cmd_rdy
//                handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tour_cmd_seq;

    logic clk;
    logic rst;
    tour_cmd_seq_if bus ();

    tour_cmd_seq dut (
        .clk     (clk),
        .rst     (rst),
        .tour_if (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-computed leg commands indexed by the lowest set move bit
    logic [15:0] vt [8];
    logic [15:0] ht [8];
    initial begin
        vt[0] = 16'h2002; ht[0] = 16'h3BF1;
        vt[1] = 16'h2002; ht[1] = 16'h33F1;
        vt[2] = 16'h2001; ht[2] = 16'h33F2;
        vt[3] = 16'h27F1; ht[3] = 16'h33F2;
        vt[4] = 16'h27F2; ht[4] = 16'h33F1;
        vt[5] = 16'h27F2; ht[5] = 16'h3BF1;
        vt[6] = 16'h27F1; ht[6] = 16'h3BF2;
        vt[7] = 16'h2001; ht[7] = 16'h3BF2;
    end

    logic [28:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;

    // Scoreboard monitor: every accepted command must match the next expectation
    always @(negedge clk) begin
        if (!rst && bus.cmd_rdy && bus.clr_cmd_rdy) begin
            logic [28:0] e;
            n_hs++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_cmd: got cmd=%h resp=%h idx=%0d, required no command",
                         bus.cmd, bus.resp, bus.mv_indx);
            end else begin
                e = exp_q.pop_front();
                if ({bus.cmd, bus.resp, bus.mv_indx} !== e) begin
                    n_err++;
                    $display("FAIL handshake: got cmd=%h resp=%h idx=%0d, required cmd=%h resp=%h idx=%0d",
                             bus.cmd, bus.resp, bus.mv_indx, e[28:13], e[12:5], e[4:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move pattern for move i: lowest bit is i%8, some moves made multi-hot
    function automatic logic [7:0] pat(input int i);
        logic [7:0] one, t, m;
        one = 8'd1 << (i % 8);
        t   = 8'd2 << (i % 8);
        m   = one;
        if (i % 3 == 0) m = m | ~(t - 8'd1);
        return m;
    endfunction

    task automatic start(input logic [7:0] mv);
        bus.move       = mv;
        bus.start_tour = 1'b1;
        tick();
        bus.start_tour = 1'b0;
        #1;
        chk("start_rdy", 16'(bus.cmd_rdy), 16'h1);
        chk("start_idx", 16'(bus.mv_indx), 16'h0);
    endtask

    task automatic do_vert(input logic [7:0] mv, input int b, input int idx);
        bus.move = mv;
        exp_q.push_back({vt[b], 8'h5A, 5'(idx)});
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("vert_no_uart_clr", 16'(bus.clr_cmd_rdy_UART), 16'h0);
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        chk("hold_v_rdy", 16'(bus.cmd_rdy), 16'h0);
    endtask

    task automatic do_horz(input int b, input int idx);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        exp_q.push_back({ht[b], 8'h5A, 5'(idx)});
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0;
        #1;
        chk("hold_h_resp", 16'(bus.resp), (idx == 23) ? 16'h00A5 : 16'h005A);
    endtask

    task automatic do_move(input logic [7:0] mv, input int b, input int idx);
        do_vert(mv, b, idx);
        do_horz(b, idx);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
    endtask

    initial begin
        int hs0;
        rst = 1'b1;
        bus.start_tour   = 1'b0;
        bus.move         = 8'h00;
        bus.cmd_UART     = 16'h0000;
        bus.cmd_rdy_UART = 1'b0;
        bus.clr_cmd_rdy  = 1'b0;
        bus.send_resp    = 1'b0;
        repeat (3) tick();
        chk("rst_idx", 16'(bus.mv_indx), 16'h0);
        chk("rst_resp", 16'(bus.resp), 16'h00A5);
        chk("rst_rdy", 16'(bus.cmd_rdy), 16'h0);
        rst = 1'b0;
        tick();

        // UART pass-through in IDLE
        bus.cmd_UART = 16'h0000; bus.cmd_rdy_UART = 1'b1; bus.clr_cmd_rdy = 1'b1;
        exp_q.push_back({16'h0000, 8'hA5, 5'd0});
        #1;
        chk("idle_clr_echo", 16'(bus.clr_cmd_rdy_UART), 16'h1);
        tick();
        bus.cmd_UART = 16'hBEEF;
        exp_q.push_back({16'hBEEF, 8'hA5, 5'd0});
        tick();
        bus.clr_cmd_rdy = 1'b0; bus.cmd_rdy_UART = 1'b0;
        tick();
        chk("idle_stays", 16'(bus.resp), 16'h00A5);

        // Full 24-move tour with a mix of one-hot and multi-hot moves
        hs0 = n_hs;
        start(pat(0));
        for (int i = 0; i < 24; i++) do_move(pat(i), i % 8, i);
        #1;
        chk("tour_cmds", 16'(n_hs - hs0), 16'd48);
        chk("tour_end_idx", 16'(bus.mv_indx), 16'd23);
        chk("tour_end_resp", 16'(bus.resp), 16'h00A5);
        chk("tour_end_rdy", 16'(bus.cmd_rdy), 16'h0);
        tick();

        // Multi-hot 8'h48 decodes as bit3, then an empty move abandons the tour
        start(8'h48);
        do_move(8'h48, 3, 0);
        bus.move = 8'h00;
        #1;
        chk("empty_move_rdy", 16'(bus.cmd_rdy), 16'h0);
        tick();
        chk("empty_move_idx", 16'(bus.mv_indx), 16'h1);
        chk("empty_move_resp", 16'(bus.resp), 16'h00A5);
        tick();

        // Asynchronous reset while in HOLD_V at move 7
        start(pat(0));
        for (int i = 0; i < 7; i++) do_move(pat(i), i % 8, i);
        do_vert(pat(7), 7, 7);
        chk("pre_rst_idx", 16'(bus.mv_indx), 16'd7);
        bus.cmd_UART = 16'h1234; bus.cmd_rdy_UART = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_idx", 16'(bus.mv_indx), 16'h0);
        chk("async_rst_rdy", 16'(bus.cmd_rdy), 16'h1);
        chk("async_rst_cmd", bus.cmd, 16'h1234);
        chk("async_rst_resp", 16'(bus.resp), 16'h00A5);
        tick();
        rst = 1'b0; bus.cmd_rdy_UART = 1'b0;
        tick();

        // UART command arriving in HOLD_H at move 5
        start(pat(0));
        for (int i = 0; i < 5; i++) do_move(pat(i), i % 8, i);
        do_vert(pat(5), 5, 5);
        do_horz(5, 5);
        bus.cmd_UART = 16'hCAFE; bus.cmd_rdy_UART = 1'b1;
        #1;
        chk("hold_h_no_clr", 16'(bus.clr_cmd_rdy_UART), 16'h0);
`ifdef TOUR_ABORT_EN
        tick();
        chk("abort_idx", 16'(bus.mv_indx), 16'd5);
        chk("abort_cmd", bus.cmd, 16'hCAFE);
        chk("abort_rdy", 16'(bus.cmd_rdy), 16'h1);
        exp_q.push_back({16'hCAFE, 8'hA5, 5'd5});
        bus.clr_cmd_rdy = 1'b1;
        #1;
        chk("abort_clr_echo", 16'(bus.clr_cmd_rdy_UART), 16'h1);
        tick();
        bus.clr_cmd_rdy = 1'b0; bus.cmd_rdy_UART = 1'b0;
`else
        tick();
        chk("pending_resp", 16'(bus.resp), 16'h005A);
        chk("pending_idx", 16'(bus.mv_indx), 16'd5);
        chk("pending_rdy", 16'(bus.cmd_rdy), 16'h0);
        bus.send_resp = 1'b1;
        tick();
        bus.send_resp = 1'b0;
        for (int i = 6; i < 24; i++) do_move(pat(i), i % 8, i);
        #1;
        chk("pending_served_cmd", bus.cmd, 16'hCAFE);
        chk("pending_served_rdy", 16'(bus.cmd_rdy), 16'h1);
        exp_q.push_back({16'hCAFE, 8'hA5, 5'd23});
        bus.clr_cmd_rdy = 1'b1;
        tick();
        bus.clr_cmd_rdy = 1'b0; bus.cmd_rdy_UART = 1'b0;
`endif
        repeat (2) tick();
        chk("scoreboard_empty", 16'(exp_q.size()), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
